deserializer: RTL and testbench

Serial-to-parallel receive stage sitting directly downstream of `serializer`. It accepts a strobed one-bit stream framed by a start marker and reassembles each word into a `WIDTH`-bit parallel output. An optional even-parity bit can follow each word. The block flags truncated frames and parity failures with single-cycle pulses.

---
 rtl/deserializer.sv | 140 ++++++++++++++
 tb/tb_deserializer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deserializer.sv
// Serial-to-parallel receive stage.
// Reassembles a strobed one-bit stream into WIDTH-bit words. A word begins
// at a bit marked by frame_start. An optional even-parity bit follows the
// last data bit. Truncated frames pulse frame_err and parity failures pulse
// parity_err; both are single-cycle pulses.
//
// Strobe semantics: the bit on ser_in (with frame_start) is consumed on every
// rising edge where ser_valid=1. No backpressure exists, so the block accepts
// one bit per clock indefinitely. frame_start has no effect when ser_valid=0.
module deserializer #(
    parameter int WIDTH     = 8,   // data bits per word, 2..32
    parameter int LSB_FIRST = 0,   // 1: first serial bit is the word LSB
    parameter int PARITY_EN = 0    // 1: an even-parity bit follows each word
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] par_out,
    output logic             par_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // cnt must be able to hold WIDTH-1 for every legal WIDTH.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;

    // Candidate shift-register values for the bit currently on ser_in.
    logic [WIDTH-1:0] sr_shift;  // sr with ser_in shifted in
    logic [WIDTH-1:0] sr_first;  // empty register holding only ser_in as bit 0
    logic             last_bit;  // this bit completes the data portion

    // Shift-direction selection and end-of-data detection.
    always_comb begin
        sr_shift = '0;
        sr_first = '0;
        if (LSB_FIRST != 0) begin
            sr_shift = {ser_in, sr[WIDTH-1:1]};
            sr_first = {ser_in, {(WIDTH-1){1'b0}}};
        end else begin
            sr_shift = {sr[WIDTH-2:0], ser_in};
            sr_first = {{(WIDTH-1){1'b0}}, ser_in};
        end
        last_bit = (cnt == CNT_LAST);
    end

    // Receive FSM: framing, assembly, parity and completion pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sr         <= '0;
            par_out    <= '0;
            par_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            // Pulses default low; they are raised for one cycle below.
            par_valid  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;

            if (ser_valid) begin
                unique case (state)
                    IDLE: begin
                        // Unframed bits are dropped while idle.
                        if (frame_start) begin
                            sr    <= sr_first;
                            cnt   <= CNT_ONE;
                            state <= SHIFT;
                        end
                    end

                    SHIFT: begin
                        if (frame_start) begin
                            // Early start: abandon the partial word and
                            // restart with this bit as bit 0.
                            frame_err <= 1'b1;
                            sr        <= sr_first;
                            cnt       <= CNT_ONE;
                        end else if (last_bit) begin
                            sr  <= sr_shift;
                            cnt <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                            end else begin
                                par_out   <= sr_shift;
                                par_valid <= 1'b1;
                                state     <= IDLE;
                            end
                        end else begin
                            sr  <= sr_shift;
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    PARITY: begin
                        if (frame_start) begin
                            frame_err <= 1'b1;
                            sr        <= sr_first;
                            cnt       <= CNT_ONE;
                            state     <= SHIFT;
                        end else begin
                            // Even parity: data XOR parity bit must be 0.
                            par_out    <= sr;
                            par_valid  <= 1'b1;
                            parity_err <= (^sr) ^ ser_in;
                            state      <= IDLE;
                        end
                    end

                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // busy and the debug view follow the state register directly.
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer.
// Three instances cover MSB-first, LSB-first and parity-enabled framing.
// Each has its own strobe; serial data and frame_start are shared.
module tb_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ser_in;
    logic       frame_start;
    logic [2:0] vld;

    logic [7:0] po [3];
    logic [2:0] pv, bz, fe, pe;
    logic [1:0] st [3];

    int n_checks = 0;
    int n_fail   = 0;

    int pv_cnt [3] = '{0, 0, 0};
    int fe_cnt [3] = '{0, 0, 0};
    int bz_cnt [3] = '{0, 0, 0};
    int overlap_cnt = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    deserializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(0)) u_msb (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(vld[0]),
        .frame_start(frame_start), .par_out(po[0]), .par_valid(pv[0]),
        .busy(bz[0]), .frame_err(fe[0]), .parity_err(pe[0]), .state_dbg(st[0]));

    deserializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY_EN(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(vld[1]),
        .frame_start(frame_start), .par_out(po[1]), .par_valid(pv[1]),
        .busy(bz[1]), .frame_err(fe[1]), .parity_err(pe[1]), .state_dbg(st[1]));

    deserializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY_EN(1)) u_par (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_valid(vld[2]),
        .frame_start(frame_start), .par_out(po[2]), .par_valid(pv[2]),
        .busy(bz[2]), .frame_err(fe[2]), .parity_err(pe[2]), .state_dbg(st[2]));

    // Pulse / busy monitor, sampled shortly after each active edge.
    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (pv[i]) pv_cnt[i]++;
            if (fe[i]) fe_cnt[i]++;
            if (bz[i]) bz_cnt[i]++;
            if (pv[i] && fe[i]) overlap_cnt++;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        vld         = '0;
        frame_start = 1'b0;
        ser_in      = 1'b0;
    endtask

    task automatic drive(input int sel, input logic b, input logic fs);
        vld         = '0;
        vld[sel]    = 1'b1;
        ser_in      = b;
        frame_start = fs;
    endtask

    // Present the 8 bits of 'bits' in serial order (bits[7] first). Called
    // at a falling edge; returns at the falling edge after the last bit is
    // consumed, with the last bit still driven.
    task automatic send_bits(input int sel, input logic [7:0] bits, input logic fs, input logic gap);
        for (int i = 0; i < 8; i++) begin
            drive(sel, bits[7-i], fs && (i == 0));
            @(negedge clk);
            if (gap && i < 7) begin
                idle();
                @(negedge clk);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         sel;       // 0 msb-first, 1 lsb-first, 2 parity
        logic [7:0] bits;      // serial order, bits[7] sent first
        logic       use_par;
        logic       par_bit;
        logic       gap;
        logic [7:0] exp_out;
        logic       exp_perr;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int pv_snap, fe_snap, bz_snap;
        logic [4:0] part;
        logic [7:0] w;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0};  // strobe gaps
        vecs[2] = '{0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3] = '{1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0};  // palindrome
        vecs[4] = '{1, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0};  // 0,0,0,0,1,1,1,1
        vecs[5] = '{1, 8'hCA, 1'b0, 1'b0, 1'b0, 8'h53, 1'b0};  // 1,1,0,0,1,0,1,0
        vecs[6] = '{2, 8'h03, 1'b1, 1'b0, 1'b0, 8'h03, 1'b0};
        vecs[7] = '{2, 8'h07, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1};
        vecs[8] = '{2, 8'h07, 1'b1, 1'b1, 1'b0, 8'h07, 1'b0};
        vecs[9] = '{2, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset par_out[%0d]", i), 32'(po[i]), 32'h0);
            check($sformatf("reset par_valid[%0d]", i), 32'(pv[i]), 32'h0);
            check($sformatf("reset busy[%0d]", i), 32'(bz[i]), 32'h0);
            check($sformatf("reset frame_err[%0d]", i), 32'(fe[i]), 32'h0);
            check($sformatf("reset parity_err[%0d]", i), 32'(pe[i]), 32'h0);
            check($sformatf("reset state[%0d]", i), 32'(st[i]), 32'h0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- busy window on a plain word ----------------
        bz_snap = bz_cnt[0];
        pv_snap = pv_cnt[0];
        send_bits(0, 8'hA5, 1'b1, 1'b0);
        check("busy par_valid", 32'(pv[0]), 32'h1);
        check("busy par_out", 32'(po[0]), 32'hA5);
        check("busy low after final bit", 32'(bz[0]), 32'h0);
        idle();
        @(negedge clk);
        // High from the cycle after bit 0 through the cycle of bit 7.
        check("busy cycles", 32'(bz_cnt[0] - bz_snap), 32'd7);
        check("busy pulse count", 32'(pv_cnt[0] - pv_snap), 32'd1);

        // ---------------- table ----------------
        for (int k = 0; k < NV; k++) begin
            int s;
            s = vecs[k].sel;
            pv_snap = pv_cnt[s];
            send_bits(s, vecs[k].bits, 1'b1, vecs[k].gap);
            if (vecs[k].use_par) begin
                drive(s, vecs[k].par_bit, 1'b0);
                @(negedge clk);
            end
            check($sformatf("vec%0d par_valid", k), 32'(pv[s]), 32'h1);
            check($sformatf("vec%0d par_out", k), 32'(po[s]), 32'(vecs[k].exp_out));
            check($sformatf("vec%0d parity_err", k), 32'(pe[s]), 32'(vecs[k].exp_perr));
            idle();
            @(negedge clk);
            check($sformatf("vec%0d pulse end", k), 32'(pv[s] | pe[s]), 32'h0);
            check($sformatf("vec%0d held", k), 32'(po[s]), 32'(vecs[k].exp_out));
            check($sformatf("vec%0d pulses", k), 32'(pv_cnt[s] - pv_snap), 32'd1);
        end

        // ---------------- back-to-back frames ----------------
        pv_snap = pv_cnt[0];
        send_bits(0, 8'h12, 1'b1, 1'b0);
        check("b2b first par_out", 32'(po[0]), 32'h12);
        send_bits(0, 8'h34, 1'b1, 1'b0);
        check("b2b second par_valid", 32'(pv[0]), 32'h1);
        check("b2b second par_out", 32'(po[0]), 32'h34);
        idle();
        @(negedge clk);
        check("b2b pulses", 32'(pv_cnt[0] - pv_snap), 32'd2);

        // ---------------- abort in SHIFT ----------------
        pv_snap = pv_cnt[0];
        fe_snap = fe_cnt[0];
        part = 5'b11010;
        for (int i = 0; i < 5; i++) begin
            drive(0, part[4-i], i == 0);
            @(negedge clk);
        end
        w = 8'h81;
        drive(0, w[7], 1'b1);
        @(negedge clk);
        check("abort frame_err", 32'(fe[0]), 32'h1);
        check("abort par_valid", 32'(pv[0]), 32'h0);
        check("abort par_out kept", 32'(po[0]), 32'h34);
        check("abort busy", 32'(bz[0]), 32'h1);
        for (int i = 1; i < 8; i++) begin
            drive(0, w[7-i], 1'b0);
            @(negedge clk);
        end
        check("abort new par_valid", 32'(pv[0]), 32'h1);
        check("abort new par_out", 32'(po[0]), 32'h81);
        idle();
        @(negedge clk);
        check("abort frame_err count", 32'(fe_cnt[0] - fe_snap), 32'd1);
        check("abort pulse count", 32'(pv_cnt[0] - pv_snap), 32'd1);

        // ---------------- abort in PARITY ----------------
        fe_snap = fe_cnt[2];
        send_bits(2, 8'h55, 1'b1, 1'b0);
        check("par abort no early valid", 32'(pv[2]), 32'h0);
        drive(2, w[7], 1'b1);
        @(negedge clk);
        check("par abort frame_err", 32'(fe[2]), 32'h1);
        check("par abort par_valid", 32'(pv[2]), 32'h0);
        for (int i = 1; i < 8; i++) begin
            drive(2, w[7-i], 1'b0);
            @(negedge clk);
        end
        drive(2, 1'b0, 1'b0);
        @(negedge clk);
        check("par abort new par_out", 32'(po[2]), 32'h81);
        check("par abort parity_err", 32'(pe[2]), 32'h0);
        idle();
        @(negedge clk);
        check("par abort frame_err count", 32'(fe_cnt[2] - fe_snap), 32'd1);

        // ---------------- reset mid-frame ----------------
        fe_snap = fe_cnt[0];
        pv_snap = pv_cnt[0];
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, i == 0);
            @(negedge clk);
        end
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid reset par_out", 32'(po[0]), 32'h0);
        check("mid reset busy", 32'(bz[0]), 32'h0);
        check("mid reset state", 32'(st[0]), 32'h0);
        check("mid reset pulses", 32'({pv[0], fe[0], pe[0]}), 32'h0);
        bz_snap = bz_cnt[0];
        send_bits(0, 8'hFF, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        check("unframed busy", 32'(bz_cnt[0] - bz_snap), 32'd0);
        check("unframed par_valid", 32'(pv_cnt[0] - pv_snap), 32'd0);
        check("mid reset frame_err", 32'(fe_cnt[0] - fe_snap), 32'd0);
        send_bits(0, 8'h5A, 1'b1, 1'b0);
        check("post reset par_valid", 32'(pv[0]), 32'h1);
        check("post reset par_out", 32'(po[0]), 32'h5A);
        idle();
        @(negedge clk);

        // ---------------- global ----------------
        check("par_valid/frame_err overlap", 32'(overlap_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
